// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall controller for the 5-stage MIPS pipeline.
// Tracks EX/MEM destination records and emits registered ALU-operand mux selects.
module fwd_hazard_unit #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] SelRf  = 2'b00;
  localparam logic [1:0] SelMem = 2'b01;
  localparam logic [1:0] SelWb  = 2'b10;

  // WB producers are covered by the write-before-read register file, so only
  // the EX and MEM records feed the forwarding decision.
  logic             ex_valid_q, ex_valid_d;
  logic [REG_W-1:0] ex_dest_q, ex_dest_d;
  logic             ex_regwrite_q, ex_regwrite_d;
  logic             ex_memread_q, ex_memread_d;
  logic             mem_valid_q, mem_valid_d;
  logic [REG_W-1:0] mem_dest_q, mem_dest_d;
  logic             mem_regwrite_q, mem_regwrite_d;
  logic [1:0]       fwd_a_sel_q, fwd_a_sel_d;
  logic [1:0]       fwd_b_sel_q, fwd_b_sel_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic ex_load_hit;
  logic issue;

  function automatic logic is_producer(input logic v, input logic rw,
                                       input logic [REG_W-1:0] dest,
                                       input logic [REG_W-1:0] r);
    return v & rw & (dest == r) & (dest != '0);
  endfunction

  function automatic logic [1:0] pick_sel(input logic uses, input logic [REG_W-1:0] r,
                                          input logic exv, input logic exrw,
                                          input logic [REG_W-1:0] exd,
                                          input logic memv, input logic memrw,
                                          input logic [REG_W-1:0] memd);
    if (!uses) return SelRf;
    // The EX instruction is the younger writer and will sit in MEM next cycle.
    if (is_producer(exv, exrw, exd, r)) return SelMem;
    if (is_producer(memv, memrw, memd, r)) return SelWb;
    return SelRf;
  endfunction

  always_comb begin
    ex_load_hit = ex_valid_q & ex_memread_q & ex_regwrite_q & (ex_dest_q != '0);
    stall = ~rst & id_valid & ~flush & ex_load_hit &
            ((id_uses_rs & (id_rs == ex_dest_q)) | (id_uses_rt & (id_rt == ex_dest_q)));
    issue = id_valid & ~flush & ~stall;

    ex_valid_d    = issue;
    ex_dest_d     = id_dest;
    ex_regwrite_d = id_regwrite;
    ex_memread_d  = id_memread;

    mem_valid_d    = ex_valid_q;
    mem_dest_d     = ex_dest_q;
    mem_regwrite_d = ex_regwrite_q;

    fwd_a_sel_d = SelRf;
    fwd_b_sel_d = SelRf;
    if (issue) begin
      fwd_a_sel_d = pick_sel(id_uses_rs, id_rs, ex_valid_q, ex_regwrite_q, ex_dest_q,
                             mem_valid_q, mem_regwrite_q, mem_dest_q);
      fwd_b_sel_d = pick_sel(id_uses_rt, id_rt, ex_valid_q, ex_regwrite_q, ex_dest_q,
                             mem_valid_q, mem_regwrite_q, mem_dest_q);
    end

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_dest_q      <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_dest_q     <= '0;
      mem_regwrite_q <= 1'b0;
      fwd_a_sel_q    <= SelRf;
      fwd_b_sel_q    <= SelRf;
      stall_count_q  <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_dest_q      <= ex_dest_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_valid_q    <= mem_valid_d;
      mem_dest_q     <= mem_dest_d;
      mem_regwrite_q <= mem_regwrite_d;
      fwd_a_sel_q    <= fwd_a_sel_d;
      fwd_b_sel_q    <= fwd_b_sel_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign fwd_a_sel   = fwd_a_sel_q;
  assign fwd_b_sel   = fwd_b_sel_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: driver queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_fwd_hazard_unit;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [REG_W-1:0] id_rs, id_rt, id_dest;
  logic             id_uses_rs, id_uses_rt, id_regwrite, id_memread, flush;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .id_dest    (id_dest),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .flush      (flush),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .stall      (stall),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    int         stall;  // -1: not checked this cycle
    logic [1:0] a;
    logic [1:0] b;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   tag    = 0;

  // Monitor: every cycle presents one observation, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.stall >= 0) begin
        checks++;
        if (stall === e.stall[0]) passes++;
        else $display("FAIL stall step %0d: got %0b want %0d", e.tag, stall, e.stall);
      end
      checks++;
      if (fwd_a_sel === e.a) passes++;
      else $display("FAIL fwd_a_sel step %0d: got %b want %b", e.tag, fwd_a_sel, e.a);
      checks++;
      if (fwd_b_sel === e.b) passes++;
      else $display("FAIL fwd_b_sel step %0d: got %b want %b", e.tag, fwd_b_sel, e.b);
      checks++;
      if (stall_count === CNT_W'(e.cnt)) passes++;
      else $display("FAIL stall_count step %0d: got %0d want %0d", e.tag, stall_count, e.cnt);
    end
  end

  // One pipeline cycle: drive ID inputs, queue what must be seen this cycle.
  task automatic cyc(input logic r, input logic v, input int rs, input int rt,
                     input logic urs, input logic urt, input int dst, input logic rw,
                     input logic mr, input logic fl,
                     input int es, input logic [1:0] ea, input logic [1:0] eb,
                     input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_rs = REG_W'(rs); id_rt = REG_W'(rt);
    id_uses_rs = urs; id_uses_rt = urt; id_dest = REG_W'(dst);
    id_regwrite = rw; id_memread = mr; flush = fl;
    e.tag = tag; e.stall = es; e.a = ea; e.b = eb; e.cnt = ec;
    exp_q.push_back(e);
    tag++;
  endtask

  task automatic nop(input int es, input logic [1:0] ea, input logic [1:0] eb, input int ec);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, es, ea, eb, ec);
  endtask

  initial begin
    int c;
    rst = 1'b1; id_valid = 0; id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
    id_dest = '0; id_regwrite = 0; id_memread = 0; flush = 0;
    repeat (2) @(posedge clk);

    // Consecutive ALU hazard; first cycle also checks the reset state.
    cyc(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0);  // add $3
    cyc(0, 1, 3, 4, 1, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00, 0);  // sub rs=$3
    nop(0, 2'b01, 2'b00, 0);
    // Distance-two hazard on rt.
    cyc(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0);  // add $3
    nop(0, 2'b00, 2'b00, 0);
    cyc(0, 1, 1, 3, 1, 1, 7, 1, 0, 0, 0, 2'b00, 2'b00, 0);  // and rt=$3
    nop(0, 2'b00, 2'b10, 0);
    // Two writers of $3: EX wins over MEM.
    cyc(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc(0, 1, 3, 3, 1, 1, 8, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    nop(0, 2'b01, 2'b01, 0);
    // Load-use: one stall, bubble, then forward from MEM/WB.
    cyc(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 0);  // lw $5
    cyc(0, 1, 5, 5, 1, 1, 9, 1, 0, 0, 1, 2'b00, 2'b00, 0);  // add $5,$5
    cyc(0, 1, 5, 5, 1, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00, 1);  // re-issued
    nop(0, 2'b10, 2'b10, 1);
    // $0 writes are never forwarded.
    cyc(0, 1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(0, 1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    nop(0, 2'b00, 2'b00, 1);
    // Unused rt operand that matches a producer.
    cyc(0, 1, 1, 2, 1, 1, 4, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(0, 1, 1, 4, 1, 0, 10, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    nop(0, 2'b00, 2'b00, 1);
    // Flush overrides a load-use hazard.
    cyc(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 1);  // lw $5
    cyc(0, 1, 5, 2, 1, 1, 9, 1, 0, 1, 0, 2'b00, 2'b00, 1);  // flushed reader
    nop(0, 2'b00, 2'b00, 1);
    // Back-to-back loads feeding one instruction: single stall.
    cyc(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 1);  // lw $5
    cyc(0, 1, 1, 0, 1, 0, 6, 1, 1, 0, 0, 2'b00, 2'b00, 1);  // lw $6
    cyc(0, 1, 5, 6, 1, 1, 9, 1, 0, 0, 1, 2'b00, 2'b00, 1);
    cyc(0, 1, 5, 6, 1, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00, 2);
    nop(0, 2'b00, 2'b10, 2);  // $5 is in WB: register file supplies it
    // Saturation: 20 more stalls on a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      c = (2 + i > 15) ? 15 : 2 + i;
      cyc(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, (i == 0) ? 2'b00 : 2'b10,
          (i == 0) ? 2'b00 : 2'b10, c);
      cyc(0, 1, 5, 5, 1, 1, 9, 1, 0, 0, 1, 2'b00, 2'b00, c);
      c = (3 + i > 15) ? 15 : 3 + i;
      cyc(0, 1, 5, 5, 1, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00, c);
    end
    nop(0, 2'b10, 2'b10, 15);
    // Reset asserted while a load-use hazard is pending.
    cyc(0, 1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00, 15);
    cyc(1, 1, 5, 5, 1, 1, 9, 1, 0, 0, -1, 2'b00, 2'b00, 15);
    cyc(0, 1, 5, 5, 1, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    nop(0, 2'b00, 2'b00, 0);

    c = 0;
    while (exp_q.size() > 0 && c < 20) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
